// File: rtl/conv_window_gen.sv
// Sliding 3x3 window generator: two line buffers plus a 3x3 shift window turn a
// raster pixel stream into fully-populated windows for the 3x3 convolution unit.
module conv_window_gen #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [9*DATA_W-1:0]   win_data,
  output logic                  win_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] lb0 [IMG_W];   // row r-1
  logic [DATA_W-1:0] lb1 [IMG_W];   // row r-2
  logic [DATA_W-1:0] win      [9];
  logic [DATA_W-1:0] next_win [9];
  logic              acc, emit, col_end, row_end;

  assign in_ready = !win_valid | win_ready;
  assign acc      = in_valid & in_ready;
  assign col_end  = (col == COL_LAST);
  assign row_end  = (row == ROW_LAST);
  // Edges of the frame (col/row < 2) hold stale columns and are never emitted.
  assign emit     = acc & (col >= COL_MIN) & (row >= ROW_MIN);

  // NOTE: every always_comb output gets a value on every path (here each element
  // is written unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      next_win[3*r]     = win[3*r+1];
      next_win[3*r + 1] = win[3*r+2];
    end
    next_win[2] = lb1[col];
    next_win[5] = lb0[col];
    next_win[8] = in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values, e.g. lb1 picks up the old lb0 word, not the one written now.
  // NOTE: the line buffers are reset explicitly so a post-reset frame starts from
  // a known all-zero history; this rules out block-RAM mapping for them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
    end else if (acc) begin
      lb0[col] <= in_data;
      lb1[col] <= lb0[col];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) win[k] <= '0;
    end else if (acc) begin
      for (int k = 0; k < 9; k++) win[k] <= next_win[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Output register: a load can only happen when in_ready is high, so a held
  // window is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_data  <= '0;
    end else if (emit) begin
      win_valid <= 1'b1;
      win_last  <= col_end & row_end;
      for (int k = 0; k < 9; k++) win_data[DATA_W*k +: DATA_W] <= next_win[k];
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: expected ramp windows are queued as each
// frame is driven, and a monitor pops and compares on every window handshake.
module tb_conv_window_gen;

  localparam int DW = 16;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int KW = 9 * DW;

  typedef struct {
    logic [KW-1:0] data;
    logic          last;
  } win_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          win_valid;
  logic          win_ready;
  logic [KW-1:0] win_data;
  logic          win_last;

  win_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   pops = 0;
  bit   count_rows = 0;
  int   row_cnt [H];
  int   col_bad = 0;

  always #5 clk = ~clk;

  conv_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_data (win_data),
    .win_last (win_last)
  );

  task automatic check(input string name, input logic [KW-1:0] got, input logic [KW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Ramp pixel (r,c) = off + W*r + c; window at (r,c) covers rows r-2..r, cols c-2..c.
  function automatic logic [KW-1:0] ramp_win(input int off, input int r, input int c);
    logic [KW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++)
      w[DW*k +: DW] = DW'(off + W * (r - 2 + k / 3) + (c - 2 + k % 3));
    return w;
  endfunction

  task automatic push_frame(input int off);
    win_t e;
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        e.data = ramp_win(off, r, c);
        e.last = (r == H - 1) && (c == W - 1);
        exp_q.push_back(e);
      end
  endtask

  // Monitor: DUT inputs change only just after posedge, so negedge sees the
  // values the next posedge will act on.
  always @(negedge clk) begin
    if (rst_n && win_valid && win_ready) begin
      win_t e;
      int   v;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_window: got %h expected none", win_data);
      end else begin
        e = exp_q.pop_front();
        check("win_data", win_data, e.data);
        check("win_last", KW'(win_last), KW'(e.last));
      end
      pops++;
      if (count_rows) begin
        v = int'(win_data[8*DW +: DW]);
        if (v / W < H) row_cnt[v / W]++;
        if (v % W < 2) col_bad++;
      end
    end
  end

  // mode 0: continuous, 1: random gaps/backpressure, 2: 5-cycle stall at pixel 30.
  task automatic send_frame(input int off, input int mode, input int stop_after);
    int idx = 0;
    int cyc = 0;
    bit bp_done = 0;
    logic [KW-1:0] held;
    push_frame(off);
    while (idx < W * H && idx < stop_after) begin
      @(posedge clk); #1;
      if (mode == 2 && !bp_done && idx == 30 && win_valid) begin
        bp_done   = 1;
        win_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(off + idx);
        held      = win_data;
        repeat (5) begin
          #1;
          check("bp_in_ready", KW'(in_ready), KW'(0));
          check("bp_win_valid", KW'(win_valid), KW'(1));
          check("bp_win_data", win_data, held);
          @(posedge clk); #1;
        end
      end
      if (mode == 1) begin
        in_valid  = 1'($urandom_range(0, 1));
        win_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b1;
        win_ready = 1'b1;
      end
      in_data = in_valid ? DW'(off + idx) : 16'hdead;
      #1;
      if (in_valid && in_ready) idx++;
      cyc++;
      if (cyc > 5000) begin
        n_checks++;
        n_errors++;
        $display("FAIL frame_timeout: got %0d pixels expected %0d", idx, W * H);
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_data   = '0;
    win_ready = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", KW'(exp_q.size()), KW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    win_ready = 1'b0;
    #12;
    check("rst_win_valid", KW'(win_valid), KW'(0));
    check("rst_win_last", KW'(win_last), KW'(0));
    check("rst_win_data", win_data, KW'(0));
    check("rst_in_ready", KW'(in_ready), KW'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp frame with per-row accounting.
    pops = 0;
    count_rows = 1;
    for (int r = 0; r < H; r++) row_cnt[r] = 0;
    send_frame(0, 0, W * H);
    idle();
    drain();
    count_rows = 0;
    check("t1_count", KW'(pops), KW'(36));
    for (int r = 0; r < H; r++)
      check($sformatf("row%0d_windows", r), KW'(row_cnt[r]), KW'((r >= 2) ? 6 : 0));
    check("col_lt2_windows", KW'(col_bad), KW'(0));

    // Backpressure stall.
    pops = 0;
    send_frame(0, 2, W * H);
    idle();
    drain();
    check("t2_count", KW'(pops), KW'(36));

    // Random gaps and random downstream readiness.
    pops = 0;
    send_frame(0, 1, W * H);
    idle();
    drain();
    check("t3_count", KW'(pops), KW'(36));

    // Two back-to-back frames, second offset by 100.
    pops = 0;
    send_frame(0, 0, W * H);
    send_frame(100, 0, W * H);
    idle();
    drain();
    check("t4_count", KW'(pops), KW'(72));

    // Asynchronous reset mid-frame with a window pending.
    send_frame(0, 0, 30);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t5_pending", KW'(win_valid), KW'(1));
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_win_valid", KW'(win_valid), KW'(0));
    check("t5_rst_win_data", win_data, KW'(0));
    check("t5_rst_in_ready", KW'(in_ready), KW'(1));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pops = 0;
    send_frame(0, 0, W * H);
    idle();
    drain();
    check("t5_count", KW'(pops), KW'(36));

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
